// File: rtl/ssr_grant_sequencer.sv
// ssr_grant_sequencer: round-robin one-hot grant source (in: clk, rst_n, enable, req, done; out: ssr_bits, grant_id, busy, timeout_err)
module ssr_grant_sequencer #(
  parameter int NUM_SSR = 2,
  parameter int ID_W    = 1,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_SSR-1:0] req,
  input  logic [NUM_SSR-1:0] done,
  output logic [NUM_SSR-1:0] ssr_bits,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               timeout_err
);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, REL = 2'd2} state_t;
  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d, rr_ptr_q, rr_ptr_d, rr_next;
  logic [ID_W-1:0]   sel, sel_hi, sel_lo;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              to_err_q, to_err_d;
  logic              any_hi, fire, hit, expire;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      to_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      to_err_q   <= to_err_d;
    end
  end
  always_comb begin
    sel_hi = '0;
    sel_lo = '0;
    any_hi = 1'b0;
    for (int j = NUM_SSR - 1; j >= 0; j--) begin
      if (req[j]) sel_lo = ID_W'(j);
      if (req[j] && j >= int'(rr_ptr_q)) begin
        sel_hi = ID_W'(j);
        any_hi = 1'b1;
      end
    end
    sel = any_hi ? sel_hi : sel_lo;
  end
  always_comb begin
    fire    = enable && |req;
    hit     = done[grant_id_q];
    expire  = (TIMEOUT != 0) && (cnt_q == TO_LAST);
    state_d = (state_q == IDLE)  ? (fire ? GRANT : IDLE) :
              (state_q == GRANT) ? ((hit || expire) ? REL : GRANT) : IDLE;
  end
  always_comb begin
    rr_next    = (grant_id_q == ID_W'(NUM_SSR - 1)) ? '0 : grant_id_q + 1'b1;
    grant_id_d = (state_q == IDLE && fire) ? sel : grant_id_q;
    rr_ptr_d   = (state_q == REL) ? rr_next : rr_ptr_q;
    cnt_d      = (state_q != GRANT) ? '0 : (cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    to_err_d   = (state_q == GRANT) && !hit && expire;
  end
  always_comb begin
    ssr_bits    = (state_q == GRANT) ? NUM_SSR'(1) << grant_id_q : '0;
    busy        = |ssr_bits;
    grant_id    = grant_id_q;
    timeout_err = to_err_q;
  end
endmodule

// File: tb/tb_ssr_grant_sequencer.sv
// tb_ssr_grant_sequencer: directed and randomized checks of ssr_grant_sequencer against a behavioural model
module tb_ssr_grant_sequencer;
  localparam int N  = 4;
  localparam int TO = 8;
  logic         clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [N-1:0] req = '0, done = '0;
  logic [N-1:0] ssr_bits;
  logic [1:0]   grant_id;
  logic         busy, timeout_err;
  int checks = 0, failures = 0;
  int m_owner = -1, m_cool = 0, m_last = 0, m_ptr = 0, m_age = 0;
  bit m_terr = 1'b0;
  ssr_grant_sequencer #(.NUM_SSR(N), .ID_W(2), .TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .done(done),
    .ssr_bits(ssr_bits), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  function automatic logic [N-1:0] m_bits();
    logic [N-1:0] b = '0;
    if (m_owner >= 0) b[m_owner] = 1'b1;
    return b;
  endfunction
  task automatic model_step();
    if (!rst_n) begin
      m_owner = -1; m_cool = 0; m_last = 0; m_ptr = 0; m_terr = 1'b0;
      return;
    end
    m_terr = 1'b0;
    if (m_owner >= 0) begin
      m_age++;
      if (done[m_owner] || m_age >= TO) begin
        m_terr  = !done[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_cool  = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (enable && |req) begin
      for (int i = 0; i < N; i++) begin
        int k = (m_ptr + i) % N;
        if (req[k]) begin
          m_owner = k; m_last = k; m_age = 0;
          break;
        end
      end
    end
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0; req = '0; done = '0;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; req = 4'b1111;
    repeat (3) tick();
    checks++; if (ssr_bits !== 4'b0) begin failures++; $display("FAIL reset_ssr got=%b exp=0000", ssr_bits); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_terr got=%b exp=0", timeout_err); end
    rst_n = 1'b1; enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ssr_bits !== 4'b0) begin failures++; $display("FAIL disabled_ssr got=%b exp=0000", ssr_bits); end
    end
  endtask
  task automatic test_single_grant();
    enable = 1'b1; req = 4'b0100;
    tick();
    checks++; if (ssr_bits !== 4'b0100) begin failures++; $display("FAIL single_ssr got=%b exp=0100", ssr_bits); end
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL single_gid got=%0d exp=2", grant_id); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    req = '0;
    repeat (2) tick();
    done = 4'b0100;
    tick();
    done = '0;
    checks++; if (ssr_bits !== 4'b0) begin failures++; $display("FAIL single_rel got=%b exp=0000", ssr_bits); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_rel_busy got=%b exp=0", busy); end
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL single_gid_hold got=%0d exp=2", grant_id); end
    repeat (2) tick();
  endtask
  task automatic test_round_robin();
    int zeros;
    do_reset();
    enable = 1'b1; req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      zeros = (g == 0) ? 0 : 1;
      while (ssr_bits === 4'b0 && zeros < 10) begin
        tick();
        if (ssr_bits === 4'b0) zeros++;
      end
      if (g > 0) begin
        checks++; if (zeros !== 2) begin failures++; $display("FAIL rr_gap g=%0d got=%0d exp=2", g, zeros); end
      end
      checks++; if (grant_id !== 2'(g % N)) begin failures++; $display("FAIL rr_order g=%0d got=%0d exp=%0d", g, grant_id, g % N); end
      checks++; if (ssr_bits !== 4'(1 << (g % N))) begin failures++; $display("FAIL rr_ssr g=%0d got=%b", g, ssr_bits); end
      tick();
      done = 4'(1 << (g % N));
      tick();
      done = '0;
    end
    req = '0;
    tick();
  endtask
  task automatic test_timeout();
    int cnt;
    do_reset();
    enable = 1'b1; req = 4'b0010;
    cnt = 0;
    while (ssr_bits !== 4'b0010 && cnt < 5) begin tick(); cnt++; end
    cnt = 1;
    while (ssr_bits === 4'b0010 && cnt < 20) begin
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_early_terr cnt=%0d got=1 exp=0", cnt); end
      tick();
      if (ssr_bits === 4'b0010) cnt++;
    end
    checks++; if (cnt !== TO) begin failures++; $display("FAIL to_len got=%0d exp=%0d", cnt, TO); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_terr got=%b exp=1", timeout_err); end
    req = 4'b0011;
    tick();
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_terr_pulse got=%b exp=0", timeout_err); end
    tick();
    checks++; if (grant_id !== 2'd0 || ssr_bits !== 4'b0001) begin failures++; $display("FAIL to_next gid=%0d ssr=%b exp=0/0001", grant_id, ssr_bits); end
    done = 4'b0001; req = '0;
    tick();
    done = '0;
    tick();
  endtask
  task automatic test_collisions();
    do_reset();
    enable = 1'b1; req = 4'b0010;
    tick();
    repeat (7) tick();
    checks++; if (ssr_bits !== 4'b0010) begin failures++; $display("FAIL coll_hold8 got=%b exp=0010", ssr_bits); end
    done = 4'b0010;
    tick();
    done = '0;
    checks++; if (ssr_bits !== 4'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL coll_done_to ssr=%b terr=%b exp=0000/0", ssr_bits, timeout_err); end
    repeat (2) tick();
    checks++; if (ssr_bits !== 4'b0010) begin failures++; $display("FAIL coll_regrant got=%b exp=0010", ssr_bits); end
    done = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ssr_bits !== 4'b0010) begin failures++; $display("FAIL coll_foreign_done got=%b exp=0010", ssr_bits); end
    end
    done = '0; enable = 1'b0; req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ssr_bits !== 4'b0010) begin failures++; $display("FAIL coll_enable_fall got=%b exp=0010", ssr_bits); end
    end
    done = 4'b0010;
    tick();
    done = '0; enable = 1'b1;
    checks++; if (ssr_bits !== 4'b0) begin failures++; $display("FAIL coll_late_done got=%b exp=0000", ssr_bits); end
    tick();
    req = 4'b0100;
    tick();
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL coll_pre_rst_gid got=%0d exp=2", grant_id); end
    rst_n = 1'b0;
    tick();
    checks++; if (ssr_bits !== 4'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL coll_rst_drop ssr=%b busy=%b terr=%b", ssr_bits, busy, timeout_err); end
    rst_n = 1'b1; req = 4'b1111;
    tick();
    checks++; if (grant_id !== 2'd0 || ssr_bits !== 4'b0001) begin failures++; $display("FAIL coll_rst_ptr gid=%0d ssr=%b exp=0/0001", grant_id, ssr_bits); end
    done = 4'b0001; req = '0;
    tick();
    done = '0;
    repeat (2) tick();
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n  = ($urandom_range(0, 199) != 0);
      enable = ($urandom_range(0, 7) != 0);
      req    = 4'($urandom);
      done   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
      tick();
      checks++; if (ssr_bits !== m_bits()) begin failures++; $display("FAIL rnd_ssr i=%0d got=%b exp=%b", i, ssr_bits, m_bits()); end
      checks++; if (grant_id !== 2'(m_last)) begin failures++; $display("FAIL rnd_gid i=%0d got=%0d exp=%0d", i, grant_id, m_last); end
      checks++; if (busy !== (m_owner >= 0)) begin failures++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, busy, m_owner >= 0); end
      checks++; if (timeout_err !== m_terr) begin failures++; $display("FAIL rnd_terr i=%0d got=%b exp=%b", i, timeout_err, m_terr); end
    end
  endtask
  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_timeout();
    test_collisions();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
